ioctl_upload_server: RTL and testbench
======================================

IOCTL_UPLOAD_SERVER -- requirements
Module: ioctl_upload_server

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset.
REQ-002 Parameter ADDR_W, default 12: the game RAM address width.
REQ-003 Parameter BASE, default 0: the game RAM address of upload byte 0.
REQ-004 Parameter LENGTH, default 64: the number of bytes served.
REQ-005 Parameter INDEX, default 4: the ioctl_index value this block answers.
REQ-006 clk_sys  in  1  system clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 save_trigger  in  1  level; a rising edge requests an upload to HPS.
REQ-009 ioctl_upload  in  1  HPS upload window active.
REQ-010 ioctl_index  in  8  HPS transfer index.
REQ-011 ioctl_rd  in  1  one-cycle HPS byte-read strobe.
REQ-012 ioctl_addr  in  25  byte offset within the upload.
REQ-013 ioctl_din  out  8  byte returned to HPS.
REQ-014 ioctl_upload_req  out  1  upload request to HPS.
REQ-015 pause_req  out  1  CPU pause request.
REQ-016 paused  in  1  CPU-paused acknowledge.
REQ-017 ram_addr  out  ADDR_W  game RAM read address.
REQ-018 ram_rd  out  1  game RAM read intent.
REQ-019 ram_data  in  8  game RAM data; valid 1 cycle after ram_rd.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, REQ, PAUSE, SERVE, FETCH and CAPTURE.
REQ-022 "Active" SHALL mean ioctl_upload=1 and ioctl_index=INDEX.
REQ-023 In IDLE, a save_trigger rising edge (registered compare) SHALL move to REQ.
REQ-024 In IDLE, Active SHALL move directly to PAUSE; this is the HPS-initiated case.
REQ-025 REQ SHALL hold ioctl_upload_req=1 until Active, then move to PAUSE; ioctl_upload_req SHALL be 0 in every other state.
REQ-026 PAUSE, SERVE, FETCH and CAPTURE SHALL hold pause_req=1.
REQ-027 PAUSE SHALL move to SERVE on paused=1.
REQ-028 An ioctl_rd arriving in PAUSE SHALL be latched (address included) and serviced on entry to SERVE, never dropped.
REQ-029 On ioctl_rd, SERVE SHALL move to FETCH.
REQ-030 FETCH (1 cycle) SHALL drive ram_rd=1 and ram_addr=BASE+ioctl_addr[ADDR_W-1:0], truncated to ADDR_W with wrap-around; it then moves to CAPTURE.
REQ-031 CAPTURE SHALL register ram_data into ioctl_din, then return to SERVE.
REQ-032 ioctl_din SHALL be valid 3 cycles after the ioctl_rd cycle and SHALL hold until the next capture.
REQ-033 An ioctl_addr >= LENGTH SHALL skip the RAM access (ram_rd stays 0) and return 8'hFF with the same latency.
REQ-034 An ioctl_rd during FETCH or CAPTURE SHALL be ignored; HPS guarantees at least 4 cycles between reads.
REQ-035 Active dropping in any state from PAUSE to CAPTURE SHALL return the FSM to IDLE next cycle and deassert pause_req.
REQ-036 Any in-flight FETCH or CAPTURE SHALL be abandoned when Active drops.
REQ-037 save_trigger edges outside IDLE SHALL be ignored and not queued.
REQ-038 paused falling while in SERVE, FETCH or CAPTURE SHALL be ignored; the block does not re-arbitrate.
REQ-039 ram_rd SHALL be high only in FETCH.

Reset
REQ-040 Reset SHALL force IDLE.
REQ-041 Reset SHALL clear ioctl_din=0, ioctl_upload_req=0, pause_req=0, ram_rd=0, ram_addr=0 and busy=0.
REQ-042 Reset SHALL clear the pending-read latch and the save_trigger edge register.
REQ-043 Reset asserted mid-operation SHALL take priority over every transition.
REQ-044 No upload SHALL resume after reset.

Structure
REQ-045 The FSM state enum and the 8'hFF fill constant SHALL live in the shared core package.
REQ-046 The block SHALL be a single module with no sub-modules.
REQ-047 The edge detector SHALL be inline.

Verification
REQ-048 Trigger scenario: save_trigger 0->1 -> ioctl_upload_req=1 next cycle; Active with INDEX=4 -> req=0 and pause_req=1; paused=1 -> busy=1, state SERVE.
REQ-049 Read scenario: BASE=12'h100, RAM[12'h105]=8'hA5, ioctl_rd with addr=5 -> ram_rd=1 with ram_addr=12'h105 1 cycle later, and ioctl_din=8'hA5 3 cycles after ioctl_rd.
REQ-050 Out-of-range scenario: LENGTH=64, ioctl_rd with addr=64 -> ram_rd never asserted, and ioctl_din=8'hFF after 3 cycles.
REQ-051 Early-read scenario: ioctl_rd with addr=2 while paused=0, then paused=1 five cycles later -> RAM[BASE+2] is returned, exactly one ram_rd pulse.
REQ-052 Abort scenario: ioctl_upload drops during FETCH -> IDLE, pause_req=0 and busy=0 next cycle, and ioctl_din is not updated.
REQ-053 Reset scenario: reset asserted in SERVE -> all outputs 0 next cycle; a save_trigger held high through reset produces no request until it goes low and rises again.

Source files
------------

// File: rtl/ioctl_upload_server_pkg.sv
// Shared definitions for the ioctl upload server: FSM states, fill byte and
// fixed HPS interface widths.
package ioctl_upload_server_pkg;

  localparam int unsigned IOCTL_ADDR_W  = 25;
  localparam int unsigned IOCTL_INDEX_W = 8;
  localparam int unsigned BYTE_W        = 8;

  localparam logic [BYTE_W-1:0] FILL_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_PAUSE,
    ST_SERVE,
    ST_FETCH,
    ST_CAPTURE
  } state_e;

endpackage

// File: rtl/ioctl_upload_server.sv
// Serves a window of game RAM to the HPS over the ioctl upload channel,
// pausing the CPU for the duration of the transfer.
module ioctl_upload_server
  import ioctl_upload_server_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned BASE   = 0,
  parameter int unsigned LENGTH = 64,
  parameter int unsigned INDEX  = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     save_trigger,
  input  logic                     ioctl_upload,
  input  logic [IOCTL_INDEX_W-1:0] ioctl_index,
  input  logic                     ioctl_rd,
  input  logic [IOCTL_ADDR_W-1:0]  ioctl_addr,
  output logic [BYTE_W-1:0]        ioctl_din,
  output logic                     ioctl_upload_req,
  output logic                     pause_req,
  input  logic                     paused,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_rd,
  input  logic [BYTE_W-1:0]        ram_data,
  output logic                     busy
);

  state_e                    r_state;
  logic                      r_trig_d;
  logic                      r_trig_arm;
  logic                      r_pend;
  logic [IOCTL_ADDR_W-1:0]   r_pend_addr;
  logic                      r_oor;
  logic [BYTE_W-1:0]         r_din;
  logic                      r_upload_req;
  logic                      r_pause_req;
  logic                      r_ram_rd;
  logic [ADDR_W-1:0]         r_ram_addr;
  logic                      r_busy;

  logic                      w_active;
  logic                      w_in_xfer;
  logic                      w_trig_rise;
  logic [IOCTL_ADDR_W-1:0]   w_sel_addr;
  logic                      w_sel_oor;
  logic [ADDR_W-1:0]         w_ram_addr;

  assign w_active  = ioctl_upload && (ioctl_index == IOCTL_INDEX_W'(INDEX));
  assign w_in_xfer = (r_state == ST_PAUSE) || (r_state == ST_SERVE) ||
                     (r_state == ST_FETCH) || (r_state == ST_CAPTURE);

  // The arm bit keeps a trigger held high through reset from counting as an edge.
  assign w_trig_rise = save_trigger && !r_trig_d && r_trig_arm;

  // A read latched during PAUSE takes precedence over the live strobe.
  assign w_sel_addr = r_pend ? r_pend_addr : ioctl_addr;
  assign w_sel_oor  = 32'(w_sel_addr) >= LENGTH;
  assign w_ram_addr = ADDR_W'(BASE) + w_sel_addr[ADDR_W-1:0];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_trig_d     <= 1'b0;
      r_trig_arm   <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_addr  <= '0;
      r_oor        <= 1'b0;
      r_din        <= '0;
      r_upload_req <= 1'b0;
      r_pause_req  <= 1'b0;
      r_ram_rd     <= 1'b0;
      r_ram_addr   <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_trig_d <= save_trigger;
      if (!save_trigger) r_trig_arm <= 1'b1;

      if (w_in_xfer && !w_active) begin
        // HPS closed the window: abandon whatever is in flight.
        r_state     <= ST_IDLE;
        r_pause_req <= 1'b0;
        r_busy      <= 1'b0;
        r_ram_rd    <= 1'b0;
        r_pend      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_active) begin
              r_state     <= ST_PAUSE;
              r_pause_req <= 1'b1;
              r_busy      <= 1'b1;
            end else if (w_trig_rise) begin
              r_state      <= ST_REQ;
              r_upload_req <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
          ST_REQ: begin
            if (w_active) begin
              r_state      <= ST_PAUSE;
              r_upload_req <= 1'b0;
              r_pause_req  <= 1'b1;
            end
          end
          ST_PAUSE: begin
            if (ioctl_rd && !r_pend) begin
              r_pend      <= 1'b1;
              r_pend_addr <= ioctl_addr;
            end
            if (paused) r_state <= ST_SERVE;
          end
          ST_SERVE: begin
            if (r_pend || ioctl_rd) begin
              r_state    <= ST_FETCH;
              r_pend     <= 1'b0;
              r_oor      <= w_sel_oor;
              r_ram_rd   <= !w_sel_oor;
              r_ram_addr <= w_ram_addr;
            end
          end
          ST_FETCH: begin
            r_ram_rd <= 1'b0;
            r_state  <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            r_din   <= r_oor ? FILL_BYTE : ram_data;
            r_state <= ST_SERVE;
          end
          default: begin
            r_state      <= ST_IDLE;
            r_upload_req <= 1'b0;
            r_pause_req  <= 1'b0;
            r_ram_rd     <= 1'b0;
            r_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ioctl_din        = r_din;
  assign ioctl_upload_req = r_upload_req;
  assign pause_req        = r_pause_req;
  assign ram_rd           = r_ram_rd;
  assign ram_addr         = r_ram_addr;
  assign busy             = r_busy;

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Self-checking bench for ioctl_upload_server: directed scenarios plus random
// reads compared against a byte-level model of the served RAM window.
module tb_ioctl_upload_server;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned BASE     = 'h100;
  localparam int unsigned LENGTH   = 64;
  localparam int unsigned INDEX    = 4;
  localparam int unsigned RAM_SIZE = 1 << ADDR_W;

  logic              clk_sys;
  logic              reset;
  logic              save_trigger;
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_upload_req;
  logic              pause_req;
  logic              paused;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_data;
  logic              busy;

  logic [7:0] mem [RAM_SIZE];
  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;

  ioctl_upload_server #(
    .ADDR_W(ADDR_W), .BASE(BASE), .LENGTH(LENGTH), .INDEX(INDEX)
  ) dut (
    .clk_sys          (clk_sys),
    .reset            (reset),
    .save_trigger     (save_trigger),
    .ioctl_upload     (ioctl_upload),
    .ioctl_index      (ioctl_index),
    .ioctl_rd         (ioctl_rd),
    .ioctl_addr       (ioctl_addr),
    .ioctl_din        (ioctl_din),
    .ioctl_upload_req (ioctl_upload_req),
    .pause_req        (pause_req),
    .paused           (paused),
    .ram_addr         (ram_addr),
    .ram_rd           (ram_rd),
    .ram_data         (ram_data),
    .busy             (busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Synchronous game RAM: data one cycle after the read strobe.
  always @(posedge clk_sys) begin
    if (ram_rd) begin
      ram_data <= mem[ram_addr];
      rd_cnt   <= rd_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  function automatic logic [7:0] model_byte(input logic [24:0] a);
    if (int'(a) >= int'(LENGTH)) return 8'hFF;
    return mem[(int'(BASE) + int'(a)) % int'(RAM_SIZE)];
  endfunction

  // One HPS byte read with full latency checks; caller is at a negedge in SERVE.
  task automatic do_read(input logic [24:0] a);
    int         c0;
    logic [7:0] prev;
    logic       oor;
    oor  = int'(a) >= int'(LENGTH);
    prev = ioctl_din;
    c0   = rd_cnt;
    ioctl_rd = 1'b1; ioctl_addr = a;
    tick();
    ioctl_rd = 1'b0;
    check("ram_rd_fetch", 32'(ram_rd), 32'(!oor));
    if (!oor) check("ram_addr", 32'(ram_addr), (int'(BASE) + int'(a)) % int'(RAM_SIZE));
    tick();
    check("din_hold", 32'(ioctl_din), 32'(prev));
    tick();
    check("din", 32'(ioctl_din), 32'(model_byte(a)));
    check("rd_pulses", rd_cnt - c0, oor ? 0 : 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_din"},   32'(ioctl_din), 0);
    check({tag, "_req"},   32'(ioctl_upload_req), 0);
    check({tag, "_pause"}, 32'(pause_req), 0);
    check({tag, "_ramrd"}, 32'(ram_rd), 0);
    check({tag, "_addr"},  32'(ram_addr), 0);
    check({tag, "_busy"},  32'(busy), 0);
  endtask

  initial begin
    int         c0;
    logic [7:0] prev;
    logic [24:0] a;

    for (int i = 0; i < int'(RAM_SIZE); i++) mem[i] = 8'($urandom);
    mem['h105] = 8'hA5;
    ram_data = 8'h00;
    reset = 1'b1; save_trigger = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
    ioctl_rd = 1'b0; ioctl_addr = '0; paused = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Host-side save request
    save_trigger = 1'b1;
    tick();
    check("trig_req", 32'(ioctl_upload_req), 1);
    check("trig_busy", 32'(busy), 1);
    ioctl_upload = 1'b1; ioctl_index = 8'd3;
    tick();
    check("wrong_index_req", 32'(ioctl_upload_req), 1);
    check("wrong_index_pause", 32'(pause_req), 0);
    // Trigger re-edge while in REQ must be ignored and not queued
    save_trigger = 1'b0; tick(); save_trigger = 1'b1;
    ioctl_index = 8'd4;
    tick();
    check("active_req", 32'(ioctl_upload_req), 0);
    check("active_pause", 32'(pause_req), 1);
    paused = 1'b1;
    tick();
    check("serve_busy", 32'(busy), 1);
    check("serve_pause", 32'(pause_req), 1);

    do_read(25'd5);
    do_read(25'd64);
    do_read(25'd63);
    do_read(25'd0);

    // Abort during FETCH
    prev = ioctl_din;
    ioctl_rd = 1'b1; ioctl_addr = 25'd7;
    tick();
    ioctl_rd = 1'b0;
    check("abort_fetch_rd", 32'(ram_rd), 1);
    ioctl_upload = 1'b0;
    tick();
    check("abort_pause", 32'(pause_req), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ramrd", 32'(ram_rd), 0);
    repeat (3) tick();
    check("abort_din", 32'(ioctl_din), 32'(prev));
    check("no_queued_trig", 32'(ioctl_upload_req), 0);

    // HPS-initiated upload with a read arriving before the CPU pauses
    paused = 1'b0;
    ioctl_upload = 1'b1;
    tick();
    check("hps_pause", 32'(pause_req), 1);
    check("hps_req", 32'(ioctl_upload_req), 0);
    c0 = rd_cnt;
    ioctl_rd = 1'b1; ioctl_addr = 25'd2;
    tick();
    ioctl_rd = 1'b0; ioctl_addr = 25'd40;
    repeat (5) tick();
    check("early_no_rd", rd_cnt - c0, 0);
    paused = 1'b1;
    tick();
    tick();
    check("early_ramrd", 32'(ram_rd), 1);
    check("early_addr", 32'(ram_addr), (int'(BASE) + 2) % int'(RAM_SIZE));
    tick();
    tick();
    check("early_din", 32'(ioctl_din), 32'(model_byte(25'd2)));
    repeat (3) tick();
    check("early_pulses", rd_cnt - c0, 1);

    // Random reads; paused wobbling mid-transfer must not matter
    for (int n = 0; n < 24; n++) begin
      paused = 1'($urandom);
      if ($urandom_range(0, 3) == 0) a = 25'($urandom_range(64, 33554431));
      else                           a = 25'($urandom_range(0, 63));
      do_read(a);
      repeat ($urandom_range(1, 4)) tick();
    end

    // Reset in SERVE with save_trigger held high through it
    reset = 1'b1; save_trigger = 1'b1; ioctl_upload = 1'b0;
    tick();
    check_idle_outputs("mid_reset");
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("held_trig_req", 32'(ioctl_upload_req), 0);
    check("held_trig_busy", 32'(busy), 0);
    save_trigger = 1'b0;
    tick();
    save_trigger = 1'b1;
    tick();
    check("retrig_req", 32'(ioctl_upload_req), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
